bsg_manycore_link_sif_credit_limiter: RTL and testbench

- Sits between a manycore endpoint (proc side, P) and the link-sif async buffer's single-clock side (network side, N).
- Limits the number of outstanding forward requests issued by P to max_out_credits_p:
  - each forward packet sent P->N consumes one credit;
  - each return packet delivered N->P restores one credit.
- Return packets N->P are buffered in a 2-entry FIFO. Forward requests N->P and returns P->N pass straight through.

---
 rtl/bsg_manycore_link_sif_credit_limiter.sv | 137 +++++++++++++
 tb/tb_bsg_manycore_link_sif_credit_limiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_link_sif_credit_limiter.sv
// Caps outstanding forward requests from an endpoint at max_out_credits_p. Returns
// toward the endpoint are buffered in a two-entry FIFO, and a credit comes back only when the endpoint takes the return.
module bsg_manycore_link_sif_credit_limiter #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int max_out_credits_p = 16,
    localparam int credit_width_lp        = $clog2(max_out_credits_p + 1),
    localparam int fwd_packet_width_lp    = addr_width_p + data_width_p
                                            + 2 * x_cord_width_p + 2 * y_cord_width_p,
    localparam int return_packet_width_lp = data_width_p + x_cord_width_p + y_cord_width_p,
    localparam int bsg_manycore_link_sif_width_lp = fwd_packet_width_lp + return_packet_width_lp + 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [bsg_manycore_link_sif_width_lp-1:0] P_link_sif_i,
    output logic [bsg_manycore_link_sif_width_lp-1:0] P_link_sif_o,
    input  logic [bsg_manycore_link_sif_width_lp-1:0] N_link_sif_i,
    output logic [bsg_manycore_link_sif_width_lp-1:0] N_link_sif_o,
    output logic [credit_width_lp-1:0]                out_credits_o,
    output logic                                      idle_o,
    output logic                                      overflow_o
);

    localparam int fw_lp = fwd_packet_width_lp;
    localparam int rw_lp = return_packet_width_lp;
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    // Link layout, MSB first: {fwd.v, fwd.data, fwd.ready_and_rev, rev.v, rev.data, rev.ready_and_rev}
    logic             p_fwd_v_li, p_fwd_ready_li, p_rev_v_li, p_rev_ready_li;
    logic [fw_lp-1:0] p_fwd_data_li;
    logic [rw_lp-1:0] p_rev_data_li;
    logic             n_fwd_v_li, n_fwd_ready_li, n_rev_v_li, n_rev_ready_li;
    logic [fw_lp-1:0] n_fwd_data_li;
    logic [rw_lp-1:0] n_rev_data_li;

    assign {p_fwd_v_li, p_fwd_data_li, p_fwd_ready_li,
            p_rev_v_li, p_rev_data_li, p_rev_ready_li} = P_link_sif_i;
    assign {n_fwd_v_li, n_fwd_data_li, n_fwd_ready_li,
            n_rev_v_li, n_rev_data_li, n_rev_ready_li} = N_link_sif_i;

    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                       overflow_q, overflow_d;
    logic [rw_lp-1:0]           mem_q [2];
    logic [rw_lp-1:0]           mem_d [2];
    logic                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]                 count_q, count_d;

    logic has_credit, n_fwd_v_lo, p_fwd_ready_lo;
    logic fifo_full, fifo_v, enq, deq, send, ret, ret_at_max;

    // NOTE: the counter resets to max, so the grant is also masked by reset_i to keep
    // both sides quiet while reset is held.
    assign has_credit     = (credits_q != '0);
    assign n_fwd_v_lo     = p_fwd_v_li & has_credit & reset_i;
    assign p_fwd_ready_lo = n_fwd_ready_li & has_credit & reset_i;
    assign send           = p_fwd_v_li & p_fwd_ready_lo;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_v     = (count_q != 2'd0);
    assign enq        = n_rev_v_li & ~fifo_full;
    assign deq        = fifo_v & p_rev_ready_li;
    assign ret        = deq;
    assign ret_at_max = ret & (credits_q == max_credits_lp);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = n_rev_data_li;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        unique case ({send, ret})
            2'b10: credits_d = credits_q - credit_width_lp'(1);
            2'b01: begin
                if (credits_q == max_credits_lp) overflow_d = 1'b1;
                else                             credits_d  = credits_q + credit_width_lp'(1);
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            credits_q  <= max_credits_lp;
            overflow_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides whether an entry is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign P_link_sif_o  = {n_fwd_v_li, n_fwd_data_li, p_fwd_ready_lo,
                            fifo_v, mem_q[rd_ptr_q], n_rev_ready_li};
    assign N_link_sif_o  = {n_fwd_v_lo, p_fwd_data_li, p_fwd_ready_li,
                            p_rev_v_li, p_rev_data_li, ~fifo_full};
    assign out_credits_o = credits_q;
    assign overflow_o    = overflow_q;
    assign idle_o        = (credits_q == max_credits_lp) & ~fifo_v;

    // A held request must stay offered until it is taken.
    a_fwd_v_held: assert property (@(posedge clk_i) disable iff (!reset_i)
        ($past(n_fwd_v_lo & ~n_fwd_ready_li) && p_fwd_v_li && $stable(p_fwd_data_li))
        |-> n_fwd_v_lo);

    // Overflow may only be raised by a return delivered with the counter already at max.
    a_overflow_cause: assert property (@(posedge clk_i) disable iff (!reset_i)
        $rose(overflow_q) |-> $past(ret_at_max));

endmodule

// File: tb/tb_bsg_manycore_link_sif_credit_limiter.sv
// Directed bench for the credit limiter: pass-through vectors, a credit step table,
// and hand-written sequences for FIFO back-pressure, overflow and mid-burst reset.
module tb_bsg_manycore_link_sif_credit_limiter;

    localparam int AW = 32, DW = 32, XW = 4, YW = 4, MAXC = 16;
    localparam int FW = AW + DW + 2 * XW + 2 * YW;
    localparam int RW = DW + XW + YW;
    localparam int LW = FW + RW + 4;
    localparam int CW = $clog2(MAXC + 1);

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    logic          pi_fwd_v = 0, pi_fwd_ready = 0, pi_rev_v = 0, pi_rev_ready = 0;
    logic [FW-1:0] pi_fwd_data = '0;
    logic [RW-1:0] pi_rev_data = '0;
    logic          ni_fwd_v = 0, ni_fwd_ready = 0, ni_rev_v = 0, ni_rev_ready = 0;
    logic [FW-1:0] ni_fwd_data = '0;
    logic [RW-1:0] ni_rev_data = '0;

    logic          po_fwd_v, po_fwd_ready, po_rev_v, po_rev_ready;
    logic [FW-1:0] po_fwd_data;
    logic [RW-1:0] po_rev_data;
    logic          no_fwd_v, no_fwd_ready, no_rev_v, no_rev_ready;
    logic [FW-1:0] no_fwd_data;
    logic [RW-1:0] no_rev_data;

    logic [LW-1:0] p_link_i, p_link_o, n_link_i, n_link_o;
    logic [CW-1:0] out_credits;
    logic          idle, overflow;

    assign p_link_i = {pi_fwd_v, pi_fwd_data, pi_fwd_ready, pi_rev_v, pi_rev_data, pi_rev_ready};
    assign n_link_i = {ni_fwd_v, ni_fwd_data, ni_fwd_ready, ni_rev_v, ni_rev_data, ni_rev_ready};
    assign {po_fwd_v, po_fwd_data, po_fwd_ready, po_rev_v, po_rev_data, po_rev_ready} = p_link_o;
    assign {no_fwd_v, no_fwd_data, no_fwd_ready, no_rev_v, no_rev_data, no_rev_ready} = n_link_o;

    bsg_manycore_link_sif_credit_limiter #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW),
        .y_cord_width_p(YW), .max_out_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .P_link_sif_i(p_link_i), .P_link_sif_o(p_link_o),
        .N_link_sif_i(n_link_i), .N_link_sif_o(n_link_o),
        .out_credits_o(out_credits), .idle_o(idle), .overflow_o(overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          n_fwd_v;
        logic [FW-1:0] n_fwd_data;
        logic          p_fwd_ready;
        logic          p_rev_v;
        logic [RW-1:0] p_rev_data;
        logic          n_rev_ready;
    } pt_t;

    typedef struct {
        logic   p_fwd_v, n_fwd_ready, n_rev_v, p_rev_ready;
        logic   exp_n_fwd_v, exp_p_fwd_ready, exp_n_rev_ready, exp_p_rev_v;
        int     exp_credits;
    } step_t;

    function automatic step_t mk(input logic a, b, c, d, e, f, g, h, input int cr);
        step_t s;
        s.p_fwd_v = a; s.n_fwd_ready = b; s.n_rev_v = c; s.p_rev_ready = d;
        s.exp_n_fwd_v = e; s.exp_p_fwd_ready = f; s.exp_n_rev_ready = g; s.exp_p_rev_v = h;
        s.exp_credits = cr;
        return s;
    endfunction

    pt_t   pts[3];
    step_t steps[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        pts[0] = '{1'b1, {20{4'hA}}, 1'b1, 1'b0, {10{4'h5}}, 1'b0};
        pts[1] = '{1'b0, {20{4'h3}}, 1'b0, 1'b1, {10{4'hC}}, 1'b1};
        pts[2] = '{1'b1, {10{8'h96}}, 1'b1, 1'b1, {5{8'h69}}, 1'b1};

        for (int i = 0; i < 16; i++) steps.push_back(mk(1, 1, 0, 1, 1, 1, 1, 0, 15 - i));
        steps.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0));   // 17th packet stalls
        steps.push_back(mk(1, 1, 1, 1, 0, 0, 1, 0, 0));   // return enqueued
        steps.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 1));   // delivered: 0 -> 1
        steps.push_back(mk(1, 1, 0, 1, 1, 1, 1, 0, 0));   // stalled packet issues
        steps.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 8; i++)
            steps.push_back(mk(0, 1, 1, 1, 0, logic'(i != 0), 1, 1, i + 1));
        steps.push_back(mk(1, 1, 0, 1, 1, 1, 1, 1, 8));   // send and ret together
        steps.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 8));

        // Reset state
        #1 reset_i = 1'b0;
        pi_fwd_v = 1'b1; ni_fwd_ready = 1'b1;
        @(posedge clk); #2;
        check("rst credits", out_credits, MAXC);
        check("rst idle", idle, 1);
        check("rst overflow", overflow, 0);
        check("rst n_fwd_v", no_fwd_v, 0);
        check("rst p_fwd_ready", po_fwd_ready, 0);
        check("rst p_rev_v", po_rev_v, 0);
        @(negedge clk);
        pi_fwd_v = 1'b0;
        reset_i = 1'b1;

        foreach (pts[i]) begin
            @(negedge clk);
            ni_fwd_v = pts[i].n_fwd_v; ni_fwd_data = pts[i].n_fwd_data;
            pi_fwd_ready = pts[i].p_fwd_ready;
            pi_rev_v = pts[i].p_rev_v; pi_rev_data = pts[i].p_rev_data;
            ni_rev_ready = pts[i].n_rev_ready;
            #1;
            check($sformatf("pt%0d p_fwd_v", i), po_fwd_v, pts[i].n_fwd_v);
            check($sformatf("pt%0d p_fwd_data", i), po_fwd_data, pts[i].n_fwd_data);
            check($sformatf("pt%0d n_fwd_ready", i), no_fwd_ready, pts[i].p_fwd_ready);
            check($sformatf("pt%0d n_rev_v", i), no_rev_v, pts[i].p_rev_v);
            check($sformatf("pt%0d n_rev_data", i), no_rev_data, pts[i].p_rev_data);
            check($sformatf("pt%0d p_rev_ready", i), po_rev_ready, pts[i].n_rev_ready);
            @(posedge clk); #1;
            check($sformatf("pt%0d credits", i), out_credits, MAXC);
        end
        @(negedge clk);
        ni_fwd_v = 0; pi_rev_v = 0;

        foreach (steps[i]) begin
            @(negedge clk);
            pi_fwd_v = steps[i].p_fwd_v; ni_fwd_ready = steps[i].n_fwd_ready;
            ni_rev_v = steps[i].n_rev_v; pi_rev_ready = steps[i].p_rev_ready;
            pi_fwd_data = FW'(i + 1); ni_rev_data = RW'(i + 100);
            #1;
            check($sformatf("step%0d n_fwd_v", i), no_fwd_v, steps[i].exp_n_fwd_v);
            check($sformatf("step%0d p_fwd_ready", i), po_fwd_ready, steps[i].exp_p_fwd_ready);
            check($sformatf("step%0d n_rev_ready", i), no_rev_ready, steps[i].exp_n_rev_ready);
            check($sformatf("step%0d p_rev_v", i), po_rev_v, steps[i].exp_p_rev_v);
            if (steps[i].exp_n_fwd_v)
                check($sformatf("step%0d n_fwd_data", i), no_fwd_data, FW'(i + 1));
            @(posedge clk); #1;
            check($sformatf("step%0d credits", i), out_credits, steps[i].exp_credits);
            if (i == 16) check("credits0 idle", idle, 0);
        end

        // FIFO back-pressure with the endpoint not taking returns
        @(negedge clk);
        pi_rev_ready = 0; pi_fwd_v = 0; ni_rev_v = 1; ni_rev_data = RW'(40'hA1);
        #1 check("bp ready0", no_rev_ready, 1);
        @(negedge clk);
        ni_rev_data = RW'(40'hB2);
        #1;
        check("bp ready1", no_rev_ready, 1);
        check("bp head A v", po_rev_v, 1);
        check("bp head A", po_rev_data, RW'(40'hA1));
        @(negedge clk);
        ni_rev_data = RW'(40'hC3);
        #1 check("bp full ready", no_rev_ready, 0);
        @(posedge clk); #1 check("bp credits held", out_credits, 8);
        @(negedge clk);
        pi_rev_ready = 1;
        #1;
        check("bp deq A", po_rev_data, RW'(40'hA1));
        check("bp full ready2", no_rev_ready, 0);
        @(posedge clk); #1 check("bp credits 9", out_credits, 9);
        @(negedge clk); #1;
        check("bp deq B", po_rev_data, RW'(40'hB2));
        check("bp ready after deq", no_rev_ready, 1);
        @(posedge clk); #1 check("bp credits 10", out_credits, 10);
        @(negedge clk);
        ni_rev_v = 0;
        #1 check("bp deq C", po_rev_data, RW'(40'hC3));
        @(posedge clk); #1 check("bp credits 11", out_credits, 11);
        @(negedge clk); #1;
        check("bp empty", po_rev_v, 0);
        check("bp idle0", idle, 0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk) ni_rev_v = 1;
            @(negedge clk) ni_rev_v = 0;
        end
        @(posedge clk); #1;
        check("refill credits", out_credits, MAXC);
        check("refill idle", idle, 1);

        // Illegal return at max credits
        @(negedge clk) ni_rev_v = 1;
        @(negedge clk) ni_rev_v = 0;
        #1 check("ovf before edge", overflow, 0);
        @(posedge clk); #1;
        check("ovf set", overflow, 1);
        check("ovf credits", out_credits, MAXC);
        @(negedge clk);
        pi_fwd_v = 1; ni_fwd_ready = 1;
        @(negedge clk);
        pi_fwd_v = 0;
        #1;
        check("ovf sticky", overflow, 1);
        check("ovf send credits", out_credits, 15);

        // Mid-burst reset: credits 5 with one return queued
        @(negedge clk) pi_fwd_v = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        pi_fwd_v = 0; pi_rev_ready = 0; ni_rev_v = 1; ni_rev_data = RW'(40'hD4);
        @(negedge clk);
        ni_rev_v = 0; pi_fwd_v = 1;
        #1;
        check("pre-rst credits", out_credits, 5);
        check("pre-rst p_rev_v", po_rev_v, 1);
        check("pre-rst n_fwd_v", no_fwd_v, 1);
        #2 reset_i = 0;
        #1;
        check("async credits", out_credits, MAXC);
        check("async p_rev_v", po_rev_v, 0);
        check("async n_fwd_v", no_fwd_v, 0);
        check("async p_fwd_ready", po_fwd_ready, 0);
        check("async overflow", overflow, 0);
        check("async idle", idle, 1);
        @(negedge clk);
        reset_i = 1;
        #1 check("release n_fwd_v", no_fwd_v, 1);
        @(posedge clk); #1 check("release send", out_credits, 15);
        @(negedge clk) pi_fwd_v = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
